ldpc_pin_host: RTL and testbench

- Pin-side master for the ldpcEncDec serial pin port; the other end of P_in_out_sel / P_inputnoutput / P_input / PO_output.
- Turns parallel register write/read requests into bit-serial pin frames.
- Used on the test/bring-up FPGA and as the bench driver for the chip-level pin path.
- Frame: select held stable, 1 setup bit-period, then DATA_W data bits MSB first.
  - Write: driven on P_input.
  - Read: sampled from PO_output after a turnaround.

---
 rtl/ldpc_pin_pkg.sv | 27 ++
 rtl/ldpc_pin_tick.sv | 35 +++
 rtl/ldpc_pin_host.sv | 165 ++++++++++++++++
 tb/tb_ldpc_pin_host.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pin_pkg.sv
// Shared types and defaults for the ldpcEncDec pin-port host.
// The state enum and the counter-width helper are used by the host and the bit-period divider.
package ldpc_pin_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SEL_W   = 16;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_TURN    = 2;

  localparam logic [DEF_SEL_W-1:0] SEL_NONE = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WR,
    ST_TURN,
    ST_RD,
    ST_END,
    ST_ERR
  } state_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ldpc_pin_tick.sv
// Bit-period divider: counts 0..CLK_DIV-1 and flags the start, middle and last cycle of each period.
// A clear restarts the period so the next cycle is a start cycle.
module ldpc_pin_tick
  import ldpc_pin_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic start,
  output logic mid,
  output logic last
);

  localparam int CW = cnt_w(CLK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || count == CW'(CLK_DIV - 1)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign start = (count == '0);
  assign mid   = (count == CW'(CLK_DIV / 2));
  assign last  = (count == CW'(CLK_DIV - 1));

endmodule

// File: rtl/ldpc_pin_host.sv
// Pin-side master for the ldpcEncDec serial pin port: converts parallel register requests
// into select/setup/data frames on P_in_out_sel, P_inputnoutput, P_input and PO_output.
module ldpc_pin_host
  import ldpc_pin_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int TURN    = DEF_TURN
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [SEL_W-1:0]  req_sel,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [SEL_W-1:0]  P_in_out_sel,
  output logic              P_inputnoutput,
  output logic              P_input,
  input  logic              PO_output
);

  localparam int BW = cnt_w(DATA_W - 1);
  localparam int TW = cnt_w((TURN > 0) ? TURN - 1 : 0);

  logic              rst_meta;
  logic              rst_n;
  logic              accept;
  logic              tick_start;
  logic              tick_mid;
  logic              tick_last;
  state_t            state;
  logic              lat_we;
  logic [DATA_W-1:0] shift;
  logic [BW-1:0]     bit_cnt;
  logic [TW-1:0]     turn_cnt;

  // NOTE: reset asserts asynchronously but releases through two flops, so no flop sees a
  // deassertion edge close to the clock.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      {rst_n, rst_meta} <= 2'b00;
    end else begin
      {rst_n, rst_meta} <= {rst_meta, 1'b1};
    end
  end

  assign accept = req_valid && req_ready;
  assign busy   = (state != ST_IDLE);

  ldpc_pin_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (wb_clk_i),
    .rst_n (rst_n),
    .clear (accept),
    .start (tick_start),
    .mid   (tick_mid),
    .last  (tick_last)
  );

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= '0;
      P_in_out_sel   <= '0;
      P_inputnoutput <= 1'b0;
      P_input        <= 1'b0;
      lat_we         <= 1'b0;
      shift          <= '0;
      bit_cnt        <= '0;
      turn_cnt       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Ready returns one cycle after the completion pulse, leaving an all-zero gap.
          if (rsp_valid) req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            lat_we    <= req_we;
            shift     <= req_wdata;
            if (req_sel == SEL_W'(SEL_NONE)) begin
              state <= ST_ERR;
            end else begin
              state          <= ST_SETUP;
              P_in_out_sel   <= req_sel;
              P_inputnoutput <= req_we;
            end
          end
        end
        ST_SETUP: begin
          if (tick_last) begin
            bit_cnt <= BW'(DATA_W - 1);
            if (lat_we) begin
              state <= ST_WR;
            end else if (TURN == 0) begin
              state <= ST_RD;
            end else begin
              state    <= ST_TURN;
              turn_cnt <= TW'(TURN - 1);
            end
          end
        end
        ST_WR: begin
          if (tick_start) begin
            P_input <= shift[DATA_W-1];
            shift   <= {shift[DATA_W-2:0], 1'b0};
          end
          if (tick_last) begin
            if (bit_cnt == '0) begin
              state   <= ST_END;
              P_input <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt - BW'(1);
            end
          end
        end
        ST_TURN: begin
          if (tick_last) begin
            if (turn_cnt == '0) begin
              state <= ST_RD;
            end else begin
              turn_cnt <= turn_cnt - TW'(1);
            end
          end
        end
        ST_RD: begin
          if (tick_mid) shift <= {shift[DATA_W-2:0], PO_output};
          if (tick_last) begin
            if (bit_cnt == '0) begin
              state <= ST_END;
            end else begin
              bit_cnt <= bit_cnt - BW'(1);
            end
          end
        end
        ST_END: begin
          if (tick_last) begin
            state          <= ST_IDLE;
            P_in_out_sel   <= '0;
            P_inputnoutput <= 1'b0;
            P_input        <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_err        <= 1'b0;
            if (!lat_we) rsp_rdata <= shift;
          end
        end
        ST_ERR: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_pin_host.sv
// Self-checking bench for ldpc_pin_host: table vectors, random traffic against a frame-level
// model with a pin-side responder/monitor, plus back-to-back, mid-frame reset and a small build.
module tb_ldpc_pin_host;

  localparam int DW = 32;
  localparam int SW = 16;
  localparam int CD = 4;
  localparam int TN = 2;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_n;
  logic          req_valid, req_ready, req_we;
  logic [SW-1:0] req_sel;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;
  logic [SW-1:0] P_in_out_sel;
  logic          P_inputnoutput, P_input, PO_output;

  logic          s_req_valid, s_req_ready, s_req_we;
  logic [SW-1:0] s_req_sel;
  logic [7:0]    s_req_wdata;
  logic          s_rsp_valid, s_rsp_err, s_busy;
  logic [7:0]    s_rsp_rdata;
  logic [SW-1:0] s_sel;
  logic          s_inout, s_pin, s_po;

  int checks = 0;
  int errors = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  ldpc_pin_host u_dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_sel(req_sel), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
    .P_in_out_sel(P_in_out_sel), .P_inputnoutput(P_inputnoutput),
    .P_input(P_input), .PO_output(PO_output)
  );

  ldpc_pin_host #(.DATA_W(8), .SEL_W(SW), .CLK_DIV(2), .TURN(TN)) u_small (
    .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we),
    .req_sel(s_req_sel), .req_wdata(s_req_wdata),
    .rsp_valid(s_rsp_valid), .rsp_err(s_rsp_err), .rsp_rdata(s_rsp_rdata), .busy(s_busy),
    .P_in_out_sel(s_sel), .P_inputnoutput(s_inout),
    .P_input(s_pin), .PO_output(s_po)
  );

  // Pin-side model of the chip: frame-relative cycle count k, period p = k / CD.
  logic [DW-1:0] rd_word, cap_word;
  logic [SW-1:0] f_sel;
  logic          f_we;
  int k = 0, p, ph, act_cnt = 0, pin_viol = 0, idle_run = 0, gap = 0;

  always @(negedge wb_clk_i) begin
    if (P_in_out_sel != '0) begin
      if (k == 0) begin
        f_sel = P_in_out_sel; f_we = P_inputnoutput; gap = idle_run;
      end else if (P_in_out_sel !== f_sel || P_inputnoutput !== f_we) begin
        pin_viol++;
      end
      p = k / CD; ph = k % CD;
      if (f_we && p >= 1 && p <= DW) begin
        if (ph == CD / 2) cap_word = {cap_word[DW-2:0], P_input};
      end else if (P_input !== 1'b0) begin
        pin_viol++;
      end
      if (!f_we && p >= 1 + TN && p < 1 + TN + DW) PO_output = rd_word[DW-1-(p-1-TN)];
      else PO_output = 1'($urandom);
      k++; act_cnt++; idle_run = 0;
    end else begin
      if (P_inputnoutput !== 1'b0 || P_input !== 1'b0) pin_viol++;
      PO_output = 1'($urandom); k = 0; idle_run++;
    end
  end

  logic [7:0] s_rd, s_cap;
  int s_k = 0, sp;

  always @(negedge wb_clk_i) begin
    if (s_sel != '0) begin
      sp = s_k / 2;
      if (s_inout && sp >= 1 && sp <= 8 && (s_k % 2) == 1) s_cap = {s_cap[6:0], s_pin};
      if (!s_inout && sp >= 1 + TN && sp < 1 + TN + 8) s_po = s_rd[7-(sp-1-TN)];
      else s_po = 1'($urandom);
      s_k++;
    end else begin
      s_po = 1'($urandom); s_k = 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge wb_clk_i); #1;
  endtask

  // Frame length in cycles from the pin protocol: setup + (turn) + data + end periods.
  function automatic int exp_lat(input logic we, input logic [SW-1:0] sel, input int dw, input int cd);
    if (sel == '0) return 2;
    return (we ? (2 + dw) : (2 + TN + dw)) * cd + 1;
  endfunction

  typedef struct {
    logic          we;
    logic [SW-1:0] sel;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int lat, a0, pv0, waited;
    a0 = act_cnt; pv0 = pin_viol; rd_word = v.rd; cap_word = '0; lat = 0;
    req_valid = 1'b1; req_we = v.we; req_sel = v.sel; req_wdata = v.wdata;
    waited = 0;
    while (!req_ready && waited < 300) begin tick(); waited++; end
    check({tag, " ready"}, req_ready, 1'b1);
    tick();
    req_valid = 1'b0; req_we = 1'($urandom); req_sel = 16'($urandom); req_wdata = $urandom;
    for (int n = 1; n <= 300; n++) begin
      if (rsp_valid) begin lat = n; break; end
      tick();
    end
    check({tag, " latency"}, lat, v.lat);
    check({tag, " err"}, rsp_err, v.exp_err);
    check({tag, " rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, " ready low at rsp"}, req_ready, 1'b0);
    tick();
    check({tag, " rsp pulse/ready"}, {rsp_valid, req_ready}, 2'b01);
    check({tag, " pin cycles"}, act_cnt - a0, (v.lat == 2) ? 0 : v.lat - 1);
    check({tag, " pin protocol"}, pin_viol - pv0, 0);
    if (v.we && !v.exp_err) check({tag, " serial wdata"}, cap_word, v.wdata);
  endtask

  task automatic run_small(input logic we, input logic [7:0] wdata, input logic [7:0] rd,
                           input logic [7:0] exp_rdata, input string tag);
    int lat;
    lat = 0; s_rd = rd; s_cap = '0;
    s_req_valid = 1'b1; s_req_we = we; s_req_sel = 16'h0005; s_req_wdata = wdata;
    check({tag, " ready"}, s_req_ready, 1'b1);
    tick();
    s_req_valid = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (s_rsp_valid) begin lat = n; break; end
      tick();
    end
    check({tag, " latency"}, lat, exp_lat(we, 16'h0005, 8, 2));
    check({tag, " err/rdata"}, {s_rsp_err, s_rsp_rdata}, {1'b0, exp_rdata});
    if (we) check({tag, " serial wdata"}, s_cap, wdata);
    tick();
  endtask

  vec_t          vecs[8];
  vec_t          rv;
  logic [DW-1:0] model_rdata;
  int            lat, seen, waited;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 16'h0003, 32'hA5A5_0F0F, 32'h0000_0000, 1'b0, 32'h0000_0000, 137};
    vecs[1] = '{1'b0, 16'h0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 145};
    vecs[2] = '{1'b1, 16'h0000, 32'h1234_5678, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 2};
    vecs[3] = '{1'b0, 16'h0000, 32'h0000_0000, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF, 2};
    vecs[4] = '{1'b1, 16'hFFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 137};
    vecs[5] = '{1'b0, 16'h8000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 145};
    vecs[6] = '{1'b0, 16'h0001, 32'h0000_0000, 32'h8000_0001, 1'b0, 32'h8000_0001, 145};
    vecs[7] = '{1'b1, 16'h8001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'h8000_0001, 137};

    wb_rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_sel = '0; req_wdata = '0;
    s_req_valid = 1'b0; s_req_we = 1'b0; s_req_sel = '0; s_req_wdata = '0;
    rd_word = '0; s_rd = '0;
    #1 wb_rst_n = 1'b0;
    tick(); tick();
    check("reset ctrl {ready,valid,err,busy,inout,pin}",
          {req_ready, rsp_valid, rsp_err, busy, P_inputnoutput, P_input}, 6'b100000);
    check("reset sel", P_in_out_sel, 16'h0000);
    check("reset rdata", rsp_rdata, 32'h0);
    wb_rst_n = 1'b1;
    tick(); tick(); tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    model_rdata = 32'h8000_0001;
    for (int i = 0; i < 16; i++) begin
      rv.we = 1'($urandom);
      rv.sel = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      rv.wdata = $urandom; rv.rd = $urandom;
      rv.exp_err = (rv.sel == '0);
      if (!rv.exp_err && !rv.we) model_rdata = rv.rd;
      rv.exp_rdata = model_rdata;
      rv.lat = exp_lat(rv.we, rv.sel, DW, CD);
      run_vec(rv, $sformatf("rand%0d", i));
    end

    // Back-to-back read then write with req_valid held; req_* scrambled while busy.
    rd_word = 32'h1234_5678; cap_word = '0; lat = 0;
    req_valid = 1'b1; req_we = 1'b0; req_sel = 16'h0010; req_wdata = 32'hFFFF_0000;
    check("b2b first ready", req_ready, 1'b1);
    tick();
    req_we = 1'b1; req_sel = 16'hBEEF; req_wdata = 32'h0BAD_0BAD;
    for (int n = 1; n <= 300; n++) begin
      if (rsp_valid) begin lat = n; break; end
      if (n == 40) begin req_sel = 16'h0021; req_wdata = 32'hC3C3_5A5A; end
      tick();
    end
    check("b2b read latency", lat, 145);
    check("b2b read rdata", rsp_rdata, 32'h1234_5678);
    check("b2b read frame sel/we", {f_sel, f_we}, {16'h0010, 1'b0});
    check("b2b ready low at rsp", req_ready, 1'b0);
    tick();
    check("b2b ready next cycle", req_ready, 1'b1);
    check("b2b idle pins", {P_in_out_sel, P_inputnoutput, P_input}, 18'h0);
    tick();
    req_valid = 1'b0;
    check("b2b second frame sel", P_in_out_sel, 16'h0021);
    check("b2b idle gap >= 1", (gap >= 1), 1'b1);
    lat = 0;
    for (int n = 1; n <= 300; n++) begin
      if (rsp_valid) begin lat = n; break; end
      tick();
    end
    check("b2b write latency", lat, 137);
    check("b2b write err/rdata", {rsp_err, rsp_rdata}, {1'b0, 32'h1234_5678});
    check("b2b write serial", cap_word, 32'hC3C3_5A5A);
    tick();

    // Reset in the middle of a read while bit 10 is on the wire.
    rd_word = $urandom;
    req_valid = 1'b1; req_we = 1'b0; req_sel = 16'h0010;
    tick();
    req_valid = 1'b0;
    for (int n = 0; n < 53; n++) tick();
    check("midreset frame active", {P_in_out_sel, busy}, {16'h0010, 1'b1});
    wb_rst_n = 1'b0;
    #1;
    check("midreset pins", {P_in_out_sel, P_inputnoutput, P_input}, 18'h0);
    check("midreset {valid,busy,ready}", {rsp_valid, busy, req_ready}, 3'b001);
    tick(); tick();
    wb_rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 160; n++) begin
      if (rsp_valid) seen++;
      tick();
    end
    check("midreset no rsp_valid", seen, 0);
    rv = '{1'b0, 16'h0010, 32'h0, 32'h0000_0001, 1'b0, 32'h0000_0001, 145};
    run_vec(rv, "post-reset read");

    // Small build: DATA_W=8, CLK_DIV=2.
    run_small(1'b1, 8'h81, 8'h00, 8'h00, "small write");
    run_small(1'b0, 8'h00, 8'h7E, 8'h7E, "small read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
